// File: rtl/hdlverifier_capture_sequencer_if.sv
// Host/buffer-side bundle of the capture sequencer: control pulses, trigger,
// buffer write addressing, readout handshake and status.
interface hdlverifier_capture_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  clk_enable;
  logic                  arm;
  logic                  abort;
  logic                  trigger;
  logic [ADDR_WIDTH-1:0] trigger_position;
  logic                  rd_start;
  logic                  rd_ready;
  logic                  buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic [ADDR_WIDTH-1:0] trigger_addr;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_last;
  logic                  busy;
  logic                  capture_done;
  logic [2:0]            state;

  modport slave (
    input  clk_enable, arm, abort, trigger, trigger_position, rd_start, rd_ready,
    output buf_wr_en, buf_wr_addr, trigger_addr, rd_valid, rd_addr, rd_last,
           busy, capture_done, state
  );

  modport master (
    output clk_enable, arm, abort, trigger, trigger_position, rd_start, rd_ready,
    input  buf_wr_en, buf_wr_addr, trigger_addr, rd_valid, rd_addr, rd_last,
           busy, capture_done, state
  );
endinterface

// File: rtl/hdlverifier_capture_sequencer.sv
// Capture-buffer sequencer: circular pre-trigger fill, trigger wait, post-trigger
// fill, then oldest-first readout of the DEPTH-sample window.
module hdlverifier_capture_sequencer #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            reset_n,
  hdlverifier_capture_sequencer_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4,
    S_READ      = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  wr_beat;
  logic [CW-1:0]         cnt_inc;
  logic [CW-1:0]         pre_ext;
  logic [CW-1:0]         post_cnt;
  logic [ADDR_WIDTH-1:0] pre_clamp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      pre_q       <= pre_d;
      trig_addr_q <= trig_addr_d;
      rd_addr_q   <= rd_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    pre_d       = pre_q;
    trig_addr_d = trig_addr_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;

    wr_beat  = bus.clk_enable &&
               ((state_q == S_FILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST));
    cnt_inc  = cnt_q + CW'(1);
    pre_ext  = CW'(pre_q);
    post_cnt = CW'(DEPTH - 1) - pre_ext;
    pre_clamp = (CW'(bus.trigger_position) > CW'(DEPTH - 1)) ?
                ADDR_WIDTH'(DEPTH - 1) : bus.trigger_position;

    // Every write beat advances the circular write pointer.
    if (wr_beat) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          wr_addr_d = '0;
          pre_d     = pre_clamp;
          cnt_d     = '0;
          state_d   = (pre_clamp != '0) ? S_FILL : S_WAIT_TRIG;
        end
      end
      S_FILL: begin
        if (wr_beat) begin
          if (cnt_inc == pre_ext) begin
            cnt_d   = '0;
            state_d = S_WAIT_TRIG;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_WAIT_TRIG: begin
        if (wr_beat && bus.trigger) begin
          trig_addr_d = wr_addr_q;
          cnt_d       = '0;
          state_d     = (post_cnt != '0) ? S_POST : S_DONE;
        end
      end
      S_POST: begin
        if (wr_beat) begin
          if (cnt_inc == post_cnt) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_DONE: begin
        if (bus.rd_start) begin
          rd_addr_d = trig_addr_q - pre_q;
          cnt_d     = '0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (bus.rd_ready) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          if (cnt_q == CW'(DEPTH - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every other input; trigger_addr is deliberately kept.
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign bus.buf_wr_en    = wr_beat;
  assign bus.buf_wr_addr  = wr_addr_q;
  assign bus.trigger_addr = trig_addr_q;
  assign bus.rd_valid     = (state_q == S_READ);
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_last      = (state_q == S_READ) && (cnt_q == CW'(DEPTH - 1));
  assign bus.busy         = (state_q == S_FILL) || (state_q == S_WAIT_TRIG) ||
                            (state_q == S_POST) || (state_q == S_READ);
  assign bus.capture_done = (state_q == S_DONE);
  assign bus.state        = 3'(state_q);
endmodule
